// File: rtl/gcd_lcm_pkg.sv
// gcd_lcm_pkg: FSM state encoding and default operand width for gcd_lcm_unit
package gcd_lcm_pkg;
  localparam int DEF_WIDTH = 32;
  typedef enum logic [2:0] {IDLE, CHECK, DIV, QUOT, MUL, DONE} state_t;
endpackage

// File: rtl/gcd_div_seq.sv
// gcd_div_seq: restoring divider, start/dividend/divisor in, one-cycle done with quotient/remainder out WIDTH cycles after start
module gcd_div_seq import gcd_lcm_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] r, q, d, sr, sq, sd, nr, nq;
  logic [WIDTH:0] trial;
  logic [CW-1:0] cnt;
  logic busy, fit;
  // the start edge already retires the first quotient bit, so done lands exactly WIDTH cycles later
  always_comb begin
    sr = start ? '0 : r;
    sq = start ? dividend : q;
    sd = start ? divisor : d;
    trial = {sr, sq[WIDTH-1]};
    fit = trial >= {1'b0, sd};
    nr = WIDTH'(trial - (fit ? {1'b0, sd} : '0));
    nq = {sq[WIDTH-2:0], fit};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        r <= nr;
        q <= nq;
        d <= divisor;
        cnt <= CW'(WIDTH - 1);
        busy <= 1'b1;
      end else if (busy) begin
        r <= nr;
        q <= nq;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  assign quotient = q;
  assign remainder = r;
endmodule

// File: rtl/gcd_lcm_unit.sv
// gcd_lcm_unit: handshaked GCD/LCM engine, in_valid/in_ready/in_a/in_b in, out_valid/out_ready/out_gcd/out_lcm out
module gcd_lcm_unit import gcd_lcm_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_gcd,
  output logic [2*WIDTH-1:0] out_lcm
);
  state_t state, nxt;
  logic [WIDTH-1:0] a_r, b_r, t1, t2, gcd_r, q_r, div_q, div_r;
  logic [2*WIDTH-1:0] lcm_r;
  logic div_start, div_done;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = in_valid ? CHECK : IDLE;
      CHECK:   nxt = t2 != '0 ? DIV : t1 != '0 ? QUOT : DONE;
      DIV:     nxt = div_done ? CHECK : DIV;
      QUOT:    nxt = div_done ? MUL : QUOT;
      MUL:     nxt = DONE;
      DONE:    nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    div_start = state == CHECK && (t1 | t2) != '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      t1 <= '0;
      t2 <= '0;
      gcd_r <= '0;
      q_r <= '0;
      lcm_r <= '0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          a_r <= in_a;
          b_r <= in_b;
          t1 <= in_a;
          t2 <= in_b;
        end
        CHECK: begin
          if (t2 == '0) gcd_r <= t1;
          if ((t1 | t2) == '0) lcm_r <= '0;
        end
        DIV: if (div_done) begin
          t1 <= t2;
          t2 <= div_r;
        end
        QUOT: if (div_done) q_r <= div_q;
        MUL: lcm_r <= {{WIDTH{1'b0}}, q_r} * {{WIDTH{1'b0}}, b_r};
        default: ;
      endcase
  // remainder steps run t1 / t2; once t2 hits zero the same divider forms a / gcd
  gcd_div_seq #(.WIDTH(WIDTH)) u_div (
    .clk(clk),
    .rst(rst),
    .start(div_start),
    .dividend(t2 != '0 ? t1 : a_r),
    .divisor(t2 != '0 ? t2 : t1),
    .done(div_done),
    .quotient(div_q),
    .remainder(div_r)
  );
  assign out_gcd = gcd_r;
  assign out_lcm = lcm_r;
endmodule
